// File: rtl/hex_pkg.sv
// Shared definitions for the hex frame-buffer reader and writer.
// Entry layout: q[63:48] r[47:32] depth[31:24] material[23:16], [15:0] spare.
package hex_pkg;

    localparam int HEX_WIDTH = 64;
    localparam int HEX_Q_LSB = 48;
    localparam int HEX_R_LSB = 32;
    localparam int HEX_D_LSB = 24;
    localparam int HEX_M_LSB = 16;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic [7:0]  depth;
        logic [7:0]  material;
        logic [15:0] spare;
    } hex_entry_t;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic [7:0]  depth;
        logic [7:0]  material;
        logic        last;
    } hex_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN
    } hex_state_e;

    function automatic hex_beat_t hex_unpack(
        input logic [HEX_WIDTH-1:HEX_M_LSB] raw,
        input logic                         last
    );
        hex_beat_t b;
        b.q        = raw[HEX_Q_LSB +: 16];
        b.r        = raw[HEX_R_LSB +: 16];
        b.depth    = raw[HEX_D_LSB +: 8];
        b.material = raw[HEX_M_LSB +: 8];
        b.last     = last;
        return b;
    endfunction

endpackage

// File: rtl/hex_skid_fifo.sv
// Two-entry beat FIFO between the frame-buffer read port and the stream.
// Data outputs read as zero while empty.
module hex_skid_fifo
    import hex_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_push,
    input  hex_beat_t i_data,
    input  logic      i_pop,
    output logic      o_valid,
    output hex_beat_t o_data,
    output logic [1:0] o_count
);

    hex_beat_t  r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + 2'(i_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/hex_event_reader.sv
// Scans a packed hex-entry frame buffer and streams the unpacked entries.
// Define HEX_EVENT_READER_CULL_EN to drop entries deeper than depth_max.
module hex_event_reader
    import hex_pkg::*;
#(
    parameter  int WIDTH  = HEX_WIDTH,
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_done,
    input  logic [31:0]       entry_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_q,
    output logic [15:0]       out_r,
    output logic [7:0]        out_depth,
    output logic [7:0]        out_material,
    output logic              out_last,
`ifdef HEX_EVENT_READER_CULL_EN
    input  logic [7:0]        depth_max,
    output logic [31:0]       cull_count,
`endif
    output logic              busy,
    output logic              frame_complete
);

    hex_state_e        r_state;
    hex_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_frame_complete;

    logic [31:0]       w_clamped;
    logic              w_start;
    logic              w_rd_en;
    logic              w_busy;
    logic              w_drained;
    logic              w_push;
    logic              w_pop;
    logic              w_cull;
    logic              w_credit_ok;
    logic [2:0]        w_used;
    logic [2:0]        w_next_occ;
    logic [1:0]        w_fifo_count;
    logic              w_fifo_valid;
    hex_beat_t         w_beat_in;
    hex_beat_t         w_beat_out;
    logic              w_unused;

    assign w_unused  = ^rd_data;
    assign w_clamped = (entry_count > 32'(DEPTH)) ? 32'(DEPTH) : entry_count;
    assign w_start   = (r_state == ST_IDLE) && frame_done;
    assign w_pop     = w_fifo_valid && out_ready;
    assign w_beat_in = hex_unpack(rd_data[HEX_WIDTH-1:HEX_M_LSB], r_inflight_last);
    assign w_push    = r_inflight && !w_cull;

    // A beat leaving this cycle frees its slot for a read issued now.
    assign w_used      = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_credit_ok = (w_used < 3'd2);
    assign w_next_occ  = 3'(w_fifo_count) + 3'(w_push) - 3'(w_pop);

`ifdef HEX_EVENT_READER_CULL_EN
    logic [31:0] r_cull_count;

    assign w_cull     = r_inflight && (w_beat_in.depth > depth_max);
    assign cull_count = r_cull_count;

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_cull_count <= '0;
        end else if (w_cull) begin
            r_cull_count <= r_cull_count + 32'd1;
        end
    end
`else
    assign w_cull = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_busy      = 1'b0;
        w_drained   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (frame_done && (w_clamped != 32'd0)) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_busy  = 1'b1;
                w_rd_en = w_credit_ok;
                if (w_rd_en && (r_addr == r_last_addr)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (w_next_occ == 3'd0) begin
                    w_drained   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr           <= '0;
            r_last_addr      <= '0;
            r_inflight       <= 1'b0;
            r_inflight_last  <= 1'b0;
            r_frame_complete <= 1'b0;
        end else begin
            r_inflight       <= w_rd_en;
            r_inflight_last  <= w_rd_en && (r_addr == r_last_addr);
            r_frame_complete <= w_drained || (w_start && (w_clamped == 32'd0));
            if (w_start) begin
                r_addr      <= '0;
                r_last_addr <= ADDR_W'(w_clamped - 32'd1);
            end else if (w_rd_en) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    hex_skid_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_beat_in),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_data  (w_beat_out),
        .o_count (w_fifo_count)
    );

    assign rd_en          = w_rd_en;
    assign rd_addr        = r_addr;
    assign busy           = w_busy;
    assign frame_complete = r_frame_complete;
    assign out_valid      = w_fifo_valid;
    assign out_q          = w_beat_out.q;
    assign out_r          = w_beat_out.r;
    assign out_depth      = w_beat_out.depth;
    assign out_material   = w_beat_out.material;
    assign out_last       = w_beat_out.last;

endmodule
